// File: rtl/rom_bridge.sv
// Instruction-fetch bridge: a one-word line buffer in front of a ready/valid memory port.
// A miss stalls fetch, issues one word-aligned request, and refills the buffer on the
// response; the word is then delivered by the following hit.
module rom_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_en,
  input  logic [3:0]            rom_write_en,
  input  logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_write_data,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] rom_read_data,
  output logic                  stall_req,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic                  err,
  output logic [31:0]           miss_cnt
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-3:0]   tag_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    valid_q;
  logic                    drop_q;
  logic                    hit;
  logic                    miss;
  logic                    issue;
  logic                    fill;
  logic                    bad_access;

  // Writes are unsupported, so the write data is never consumed.
  logic unused_write_data;
  assign unused_write_data = ^rom_write_data;

  assign hit        = rom_en & valid_q & (rom_addr[ADDR_WIDTH-1:2] == tag_q);
  assign miss       = rom_en & ~hit;
  assign bad_access = rom_en & ((rom_write_en != 4'b0000) | (rom_addr[1:0] != 2'b00));

  // Next-state decode plus the combinational stall and request-valid outputs.
  always_comb begin
    state_d       = state_q;
    stall_req     = 1'b0;
    mem_req_valid = 1'b0;
    issue         = 1'b0;
    fill          = 1'b0;
    case (state_q)
      StIdle: begin
        if (miss) begin
          stall_req = 1'b1;
          issue     = 1'b1;
          state_d   = StReq;
        end
      end
      StReq: begin
        stall_req     = 1'b1;
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        stall_req = 1'b1;
        if (mem_resp_valid) begin
          state_d = StIdle;
          // A flush in the response cycle discards the word just like an earlier flush.
          fill    = ~drop_q & ~flush;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Line buffer: refill on an undropped response, invalidate on flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (fill) begin
        tag_q  <= mem_req_addr[ADDR_WIDTH-1:2];
        data_q <= mem_resp_data;
      end
      if (flush) begin
        valid_q <= 1'b0;
      end else if (fill) begin
        valid_q <= 1'b1;
      end
    end
  end

  // Drop flag marks the in-flight response as stale after a flush; cleared back in idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q <= 1'b0;
    end else if (state_d == StIdle) begin
      drop_q <= 1'b0;
    end else if (flush && (state_q != StIdle)) begin
      drop_q <= 1'b1;
    end
  end

  // Request address and miss counter are captured when a miss issues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_addr <= '0;
      miss_cnt     <= 32'd0;
    end else if (issue) begin
      mem_req_addr <= {rom_addr[ADDR_WIDTH-1:2], 2'b00};
      miss_cnt     <= miss_cnt + 32'd1;
    end
  end

  // Fetch data register: loads only on an idle-state hit, otherwise holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_read_data <= '0;
    end else if ((state_q == StIdle) && hit) begin
      rom_read_data <= data_q;
    end
  end

  // Sticky error for write attempts and misaligned fetches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (bad_access) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rom_bridge.sv
// Directed bench for rom_bridge: a per-cycle vector table for the miss/hit/flush flow,
// followed by hand-written sequences for error flags and reset during a transaction.
module tb_rom_bridge;

  logic        clk;
  logic        rst;
  logic        rom_en;
  logic [3:0]  rom_write_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_write_data;
  logic        flush;
  logic [31:0] rom_read_data;
  logic        stall_req;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        err;
  logic [31:0] miss_cnt;

  int n_total;
  int n_pass;

  rom_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_en        (rom_en),
    .rom_write_en  (rom_write_en),
    .rom_addr      (rom_addr),
    .rom_write_data(rom_write_data),
    .flush         (flush),
    .rom_read_data (rom_read_data),
    .stall_req     (stall_req),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .err           (err),
    .miss_cnt      (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [31:0] addr;
    logic        fl;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        x_stall;
    logic        x_reqv;
    logic [31:0] x_addr;
    logic [31:0] x_rdata;
    logic [31:0] x_miss;
    logic        x_err;
  } vec_t;

  localparam int NV = 36;
  vec_t vecs[NV];

  function automatic vec_t mk(logic en, logic [31:0] addr, logic fl, logic rdy, logic rv,
                              logic [31:0] rd, logic x_stall, logic x_reqv,
                              logic [31:0] x_addr, logic [31:0] x_rdata, logic [31:0] x_miss,
                              logic x_err);
    vec_t v;
    v.en = en; v.addr = addr; v.fl = fl; v.rdy = rdy; v.rv = rv; v.rd = rd;
    v.x_stall = x_stall; v.x_reqv = x_reqv; v.x_addr = x_addr; v.x_rdata = x_rdata;
    v.x_miss = x_miss; v.x_err = x_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] A0 = 32'hbfc00000;
  localparam logic [31:0] A4 = 32'hbfc00004;
  localparam logic [31:0] D0 = 32'h3c1dbfc0;
  localparam logic [31:0] D1 = 32'h24080001;
  localparam logic [31:0] D2 = 32'h22222222;

  initial begin
    n_total = 0;
    n_pass  = 0;
    //            en addr fl rdy rv rdata         stall reqv reqaddr rdata miss err
    vecs[0]  = mk(1, A0, 0, 1, 0, 0,             1, 0, 32'h0, 32'h0, 0, 0);
    vecs[1]  = mk(1, A0, 0, 1, 0, 0,             1, 1, A0, 32'h0, 1, 0);
    vecs[2]  = mk(1, A0, 0, 0, 0, 0,             1, 0, A0, 32'h0, 1, 0);
    vecs[3]  = mk(1, A0, 0, 0, 0, 0,             1, 0, A0, 32'h0, 1, 0);
    vecs[4]  = mk(1, A0, 0, 0, 1, D0,            1, 0, A0, 32'h0, 1, 0);
    vecs[5]  = mk(1, A0, 0, 0, 0, 0,             0, 0, A0, 32'h0, 1, 0);
    vecs[6]  = mk(0, A0, 0, 0, 0, 0,             0, 0, A0, D0, 1, 0);
    // repeat fetch hits without a request
    vecs[7]  = mk(1, A0, 0, 0, 0, 0,             0, 0, A0, D0, 1, 0);
    vecs[8]  = mk(0, A0, 0, 0, 0, 0,             0, 0, A0, D0, 1, 0);
    // miss to next word with ready held low for five cycles
    vecs[9]  = mk(1, A4, 0, 0, 0, 0,             1, 0, A0, D0, 1, 0);
    vecs[10] = mk(1, A4, 0, 0, 0, 0,             1, 1, A4, D0, 2, 0);
    vecs[11] = mk(1, A4, 0, 0, 0, 0,             1, 1, A4, D0, 2, 0);
    vecs[12] = mk(1, A4, 0, 0, 0, 0,             1, 1, A4, D0, 2, 0);
    vecs[13] = mk(1, A4, 0, 0, 0, 0,             1, 1, A4, D0, 2, 0);
    vecs[14] = mk(1, A4, 0, 0, 0, 0,             1, 1, A4, D0, 2, 0);
    vecs[15] = mk(1, A4, 0, 1, 0, 0,             1, 1, A4, D0, 2, 0);
    vecs[16] = mk(1, A4, 0, 0, 1, D1,            1, 0, A4, D0, 2, 0);
    vecs[17] = mk(1, A4, 0, 0, 0, 0,             0, 0, A4, D0, 2, 0);
    vecs[18] = mk(0, A4, 0, 0, 0, 0,             0, 0, A4, D1, 2, 0);
    // back to A0 (evicted), flush in WAIT drops the response
    vecs[19] = mk(1, A0, 0, 0, 0, 0,             1, 0, A4, D1, 2, 0);
    vecs[20] = mk(1, A0, 0, 1, 0, 0,             1, 1, A0, D1, 3, 0);
    vecs[21] = mk(1, A0, 1, 0, 0, 0,             1, 0, A0, D1, 3, 0);
    vecs[22] = mk(1, A0, 0, 0, 1, 32'hdeadbeef,  1, 0, A0, D1, 3, 0);
    vecs[23] = mk(1, A0, 0, 0, 0, 0,             1, 0, A0, D1, 3, 0);
    vecs[24] = mk(1, A0, 0, 1, 0, 0,             1, 1, A0, D1, 4, 0);
    vecs[25] = mk(1, A0, 0, 0, 1, D0,            1, 0, A0, D1, 4, 0);
    vecs[26] = mk(1, A0, 0, 0, 0, 0,             0, 0, A0, D1, 4, 0);
    vecs[27] = mk(0, A0, 0, 0, 0, 0,             0, 0, A0, D0, 4, 0);
    // flush and response in the same WAIT cycle: response discarded
    vecs[28] = mk(1, A4, 0, 0, 0, 0,             1, 0, A0, D0, 4, 0);
    vecs[29] = mk(1, A4, 0, 1, 0, 0,             1, 1, A4, D0, 5, 0);
    vecs[30] = mk(1, A4, 1, 0, 1, 32'h11111111,  1, 0, A4, D0, 5, 0);
    vecs[31] = mk(1, A4, 0, 0, 0, 0,             1, 0, A4, D0, 5, 0);
    vecs[32] = mk(1, A4, 0, 1, 0, 0,             1, 1, A4, D0, 6, 0);
    vecs[33] = mk(1, A4, 0, 0, 1, D2,            1, 0, A4, D0, 6, 0);
    vecs[34] = mk(1, A4, 0, 0, 0, 0,             0, 0, A4, D0, 6, 0);
    vecs[35] = mk(0, A4, 0, 0, 0, 0,             0, 0, A4, D2, 6, 0);

    rst = 1'b0;
    rom_en = 1'b0;
    rom_write_en = 4'b0000;
    rom_addr = 32'h0;
    rom_write_data = 32'h12345678;
    flush = 1'b0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data = 32'h0;

    // reset state
    step();
    step();
    check("reset.rdata", rom_read_data, 32'h0);
    check("reset.reqv", {31'h0, mem_req_valid}, 32'h0);
    check("reset.reqaddr", mem_req_addr, 32'h0);
    check("reset.miss", miss_cnt, 32'h0);
    check("reset.err", {31'h0, err}, 32'h0);
    check("reset.stall", {31'h0, stall_req}, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      rom_en = vecs[i].en;
      rom_addr = vecs[i].addr;
      flush = vecs[i].fl;
      mem_req_ready = vecs[i].rdy;
      mem_resp_valid = vecs[i].rv;
      mem_resp_data = vecs[i].rd;
      #1;
      check($sformatf("v%0d.stall", i), {31'h0, stall_req}, {31'h0, vecs[i].x_stall});
      check($sformatf("v%0d.reqv", i), {31'h0, mem_req_valid}, {31'h0, vecs[i].x_reqv});
      check($sformatf("v%0d.reqaddr", i), mem_req_addr, vecs[i].x_addr);
      check($sformatf("v%0d.rdata", i), rom_read_data, vecs[i].x_rdata);
      check($sformatf("v%0d.miss", i), miss_cnt, vecs[i].x_miss);
      check($sformatf("v%0d.err", i), {31'h0, err}, {31'h0, vecs[i].x_err});
      step();
    end
    mem_resp_valid = 1'b0;
    flush = 1'b0;
    mem_req_ready = 1'b0;

    // write attempt on a hit: error set, read still served, nothing issued
    rom_en = 1'b1;
    rom_addr = A4;
    rom_write_en = 4'b0001;
    #1;
    check("wr.stall", {31'h0, stall_req}, 32'h0);
    check("wr.reqv", {31'h0, mem_req_valid}, 32'h0);
    step();
    check("wr.err", {31'h0, err}, 32'h1);
    check("wr.rdata", rom_read_data, D2);
    check("wr.miss", miss_cnt, 32'd6);
    check("wr.reqv2", {31'h0, mem_req_valid}, 32'h0);
    rom_en = 1'b0;
    rom_write_en = 4'b0000;
    for (int i = 0; i < 3; i++) step();
    check("wr.err_sticky", {31'h0, err}, 32'h1);

    // reset clears the sticky error
    rst = 1'b0;
    #1;
    check("rst2.err", {31'h0, err}, 32'h0);
    check("rst2.miss", miss_cnt, 32'h0);
    check("rst2.rdata", rom_read_data, 32'h0);
    step();
    rst = 1'b1;

    // misaligned fetch: error set, aligned word requested
    rom_en = 1'b1;
    rom_addr = 32'hbfc00006;
    #1;
    check("mis.stall", {31'h0, stall_req}, 32'h1);
    step();
    check("mis.err", {31'h0, err}, 32'h1);
    check("mis.reqaddr", mem_req_addr, A4);
    check("mis.reqv", {31'h0, mem_req_valid}, 32'h1);
    check("mis.miss", miss_cnt, 32'd1);
    rom_addr = A4;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("wait.reqv", {31'h0, mem_req_valid}, 32'h0);
    check("wait.stall", {31'h0, stall_req}, 32'h1);

    // reset asserted in WAIT abandons the transaction at once
    rst = 1'b0;
    #1;
    check("rstw.reqv", {31'h0, mem_req_valid}, 32'h0);
    check("rstw.reqaddr", mem_req_addr, 32'h0);
    check("rstw.miss", miss_cnt, 32'h0);
    check("rstw.err", {31'h0, err}, 32'h0);
    check("rstw.stall_miss", {31'h0, stall_req}, 32'h1);
    step();
    rst = 1'b1;
    rom_en = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'hcafef00d;
    step();
    mem_resp_valid = 1'b0;
    check("late.rdata", rom_read_data, 32'h0);
    check("late.stall", {31'h0, stall_req}, 32'h0);
    check("late.reqv", {31'h0, mem_req_valid}, 32'h0);
    rom_en = 1'b1;
    rom_addr = A4;
    #1;
    check("late.stall_miss", {31'h0, stall_req}, 32'h1);
    step();
    check("late.reqv_issue", {31'h0, mem_req_valid}, 32'h1);
    check("late.miss", miss_cnt, 32'd1);
    check("late.rdata2", rom_read_data, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rom_bridge.md
ROM_BRIDGE -- requirements
Module: rom_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the width of all data ports.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 rom_en  input  1  SHALL be the fetch-side access enable.
REQ-006 rom_write_en  input  4  SHALL be the fetch-side byte write enables (writes unsupported).
REQ-007 rom_addr  input  ADDR_WIDTH  SHALL be the fetch byte address.
REQ-008 rom_write_data  input  DATA_WIDTH  SHALL be accepted and ignored.
REQ-009 flush  input  1  SHALL be the pipeline flush / fetch abort.
REQ-010 rom_read_data  output  DATA_WIDTH  SHALL be the registered instruction word returned to fetch.
REQ-011 stall_req  output  1  SHALL request a fetch stall.
REQ-012 mem_req_valid / mem_req_ready  output / input  1 each  SHALL form the memory request handshake.
REQ-013 mem_req_addr  output  ADDR_WIDTH  SHALL be the word-aligned request address.
REQ-014 mem_resp_valid / mem_resp_data  input  1 / DATA_WIDTH  SHALL be the memory response.
REQ-015 err  output  1  SHALL be a sticky error flag.
REQ-016 miss_cnt  output  32  SHALL count issued memory requests.

Function
REQ-017 The block SHALL hold a one-entry line buffer: tag (rom_addr[ADDR_WIDTH-1:2]), data, valid bit.
REQ-018 The FSM SHALL have exactly three states: IDLE, REQ, WAIT.
REQ-019 Hit = rom_en & valid & (rom_addr[ADDR_WIDTH-1:2] == tag); miss = rom_en & !hit.
REQ-020 In IDLE on hit, rom_read_data SHALL load the buffer data at the next edge (1-cycle latency); stall_req SHALL be 0.
REQ-021 In IDLE on miss, the block SHALL latch {rom_addr[ADDR_WIDTH-1:2],2'b00} into mem_req_addr, increment miss_cnt (wrap at 2^32), and enter REQ at the next edge.
REQ-022 stall_req SHALL be combinational: 1 in REQ, 1 in WAIT, 1 in IDLE on miss, else 0.
REQ-023 In REQ, mem_req_valid SHALL be 1 and mem_req_addr stable until the cycle where mem_req_ready=1; the FSM SHALL then enter WAIT.
REQ-024 mem_req_valid SHALL be 0 in IDLE and WAIT; at most one request SHALL be outstanding.
REQ-025 In WAIT, on mem_resp_valid, the buffer SHALL capture tag/data with valid=1 (unless dropped) and the FSM SHALL return to IDLE; rom_read_data is then delivered by the subsequent IDLE hit.
REQ-026 mem_resp_valid outside WAIT SHALL be ignored.
REQ-027 When rom_en=0 in IDLE, no request SHALL issue and rom_read_data SHALL hold.
REQ-028 flush in any state SHALL clear the buffer valid bit at the next edge.
REQ-029 flush in REQ SHALL NOT drop mem_req_valid before acceptance; flush in REQ or WAIT SHALL set a drop flag so the pending response is consumed but not written to the buffer; the drop flag clears on return to IDLE.
REQ-030 flush and mem_resp_valid in the same WAIT cycle SHALL discard the response (flush wins).
REQ-031 rom_en=1 with rom_write_en != 0 SHALL set err; the write SHALL not be forwarded; a read still proceeds.
REQ-032 rom_addr[1:0] != 0 with rom_en=1 SHALL set err; the access proceeds on the aligned word.

Reset
REQ-033 While rst=0: state=IDLE, valid=0, drop=0, rom_read_data=0, mem_req_valid=0, mem_req_addr=0, miss_cnt=0, err=0; stall_req follows REQ-022.
REQ-034 Reset asserted in REQ or WAIT SHALL abandon the transaction immediately; a response arriving after reset release SHALL be ignored.

Verification
REQ-035 Reset release, rom_en=1, rom_addr=0xbfc00000, ready=1 at once, response 0x3c1dbfc0 three cycles later -> stall_req=1 throughout, miss_cnt=1, rom_read_data=0x3c1dbfc0 two cycles after response, stall_req=0.
REQ-036 Repeat fetch of 0xbfc00000 after fill -> no request, stall_req=0, data valid next cycle, miss_cnt unchanged.
REQ-037 mem_req_ready held 0 for 5 cycles -> mem_req_valid stays 1, mem_req_addr stable, stall_req=1.
REQ-038 flush in WAIT, then response 0xdeadbeef -> buffer not filled; refetch of same address misses, miss_cnt increments.
REQ-039 rom_en=1, rom_write_en=4'b0001 -> err=1 and stays 1 until reset; no memory write.
REQ-040 rst=0 asserted in WAIT, response arrives after release -> state IDLE, valid=0, response ignored, rom_read_data=0.
